// File: rtl/ctrl_mem_responder_pkg.sv
// ============================================================================
// Module   : ctrl_mem_pkg
// Brief    : Shared types and constants for the control-unit memory responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ctrl_mem_pkg;

  // One control-unit page is a single 512-bit host cache line.
  localparam int PAGE_W = 512;

  // Default MMIO offset of the buffer base register.
  localparam logic [15:0] BUF_OFS_DEFAULT = 16'h0020;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_ISSUE = 3'd1,
    S_RD_WAIT  = 3'd2,
    S_WR_ISSUE = 3'd3,
    S_WR_WAIT  = 3'd4
  } mem_resp_state_t;

endpackage

`default_nettype wire

// File: rtl/ctrl_mem_responder_if.sv
// ============================================================================
// Module   : ctrl_mem_responder_if
// Brief    : Page request, MMIO and host memory channel bundle.
//            slave  = responder view, master = control unit / host view.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ctrl_mem_responder_if #(
  parameter int HADDR_W = 42
);
  import ctrl_mem_pkg::*;

  // Control-unit page request side
  logic [31:0]         address;
  logic                read_request_valid;
  logic                write_request_valid;
  logic [PAGE_W-1:0]   write_data;
  logic                buffer_addr_valid;
  logic                data_valid;
  logic [PAGE_W-1:0]   read_data;
  logic                write_done;

  // MMIO write port
  logic                cfg_wr_valid;
  logic [15:0]         cfg_wr_addr;
  logic [63:0]         cfg_wr_data;

  // Host memory channel
  logic                host_rd_valid;
  logic [HADDR_W-1:0]  host_rd_addr;
  logic                host_rd_almfull;
  logic                host_rd_rsp_valid;
  logic [PAGE_W-1:0]   host_rd_rsp_data;
  logic                host_wr_valid;
  logic [HADDR_W-1:0]  host_wr_addr;
  logic [PAGE_W-1:0]   host_wr_data;
  logic                host_wr_almfull;
  logic                host_wr_rsp_valid;

  // Sticky error flags
  logic                err_drop;
  logic                err_timeout;
  logic                err_unexp;

  modport slave (
    input  address, read_request_valid, write_request_valid, write_data,
    output buffer_addr_valid, data_valid, read_data, write_done,
    input  cfg_wr_valid, cfg_wr_addr, cfg_wr_data,
    output host_rd_valid, host_rd_addr,
    input  host_rd_almfull, host_rd_rsp_valid, host_rd_rsp_data,
    output host_wr_valid, host_wr_addr, host_wr_data,
    input  host_wr_almfull, host_wr_rsp_valid,
    output err_drop, err_timeout, err_unexp
  );

  modport master (
    output address, read_request_valid, write_request_valid, write_data,
    input  buffer_addr_valid, data_valid, read_data, write_done,
    output cfg_wr_valid, cfg_wr_addr, cfg_wr_data,
    input  host_rd_valid, host_rd_addr,
    output host_rd_almfull, host_rd_rsp_valid, host_rd_rsp_data,
    input  host_wr_valid, host_wr_addr, host_wr_data,
    output host_wr_almfull, host_wr_rsp_valid,
    input  err_drop, err_timeout, err_unexp
  );

endinterface

`default_nettype wire

// File: rtl/ctrl_mem_responder_timeout.sv
// ============================================================================
// Module   : mem_resp_timeout
// Brief    : 0-based wait counter, cleared at transaction start, with an
//            expiry flag raised while the count equals TIMEOUT-1.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_resp_timeout #(
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,    // clear to 0 (transaction accepted)
  input  logic en_i,       // count while a transaction is outstanding
  output logic expired_o
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;

  // Wait counter: restarts on each accepted request, saturates at LAST.
  always_ff @(posedge clk) begin
    if (rst || start_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired_o = (cnt_q == LAST);

endmodule

`default_nettype wire

// File: rtl/ctrl_mem_responder.sv
// ============================================================================
// Module   : ctrl_mem_responder
// Brief    : Translates single-page read/write requests into host cache-line
//            requests relative to an MMIO-programmed buffer base, one
//            transaction outstanding, with sticky error reporting.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ctrl_mem_responder
  import ctrl_mem_pkg::*;
#(
  parameter int          HADDR_W = 42,
  parameter int          TIMEOUT = 4096,
  parameter logic [15:0] BUF_OFS = BUF_OFS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  ctrl_mem_responder_if.slave  bus
);

  mem_resp_state_t      state_q;
  logic [HADDR_W-1:0]   base_q;
  logic                 bav_q;
  logic [HADDR_W-1:0]   haddr_q;
  logic [HADDR_W-1:0]   haddr_d;
  logic [PAGE_W-1:0]    wdata_q;
  logic [PAGE_W-1:0]    rdata_q;
  logic                 dv_q, wd_q, hrv_q, hwv_q;
  logic                 err_drop_q, err_timeout_q, err_unexp_q;
  logic                 any_req, accept, drop, unexp, expired;

  // Host line address: base plus zero-extended page index, wrapping freely.
  assign haddr_d = base_q + HADDR_W'(bus.address);

  assign any_req = bus.read_request_valid | bus.write_request_valid;
  assign accept  = (state_q == S_IDLE) && bav_q && any_req;
  // Busy or unprogrammed drops everything; a read colliding with a write loses.
  assign drop    = (any_req && ((state_q != S_IDLE) || !bav_q)) ||
                   (accept && bus.read_request_valid && bus.write_request_valid);
  assign unexp   = (bus.host_rd_rsp_valid && (state_q != S_RD_WAIT)) ||
                   (bus.host_wr_rsp_valid && (state_q != S_WR_WAIT));

  mem_resp_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .start_i   (accept),
    .en_i      (state_q != S_IDLE),
    .expired_o (expired)
  );

  // Buffer base register; the valid flag only ever clears on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_q <= '0;
      bav_q  <= 1'b0;
    end else if (bus.cfg_wr_valid && (bus.cfg_wr_addr == BUF_OFS)) begin
      base_q <= bus.cfg_wr_data[HADDR_W-1:0];
      bav_q  <= 1'b1;
    end
  end

  // Transaction FSM with registered host requests, completions and error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      haddr_q       <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      dv_q          <= 1'b0;
      wd_q          <= 1'b0;
      hrv_q         <= 1'b0;
      hwv_q         <= 1'b0;
      err_drop_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      err_unexp_q   <= 1'b0;
    end else begin
      dv_q  <= 1'b0;
      wd_q  <= 1'b0;
      hrv_q <= 1'b0;
      hwv_q <= 1'b0;
      if (drop)  err_drop_q  <= 1'b1;
      if (unexp) err_unexp_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (accept) begin
            haddr_q <= haddr_d;
            if (bus.write_request_valid) begin
              state_q <= S_WR_ISSUE;
              wdata_q <= bus.write_data;
              hwv_q   <= !bus.host_wr_almfull;
            end else begin
              state_q <= S_RD_ISSUE;
              hrv_q   <= !bus.host_rd_almfull;
            end
          end
        end
        // hrv_q high means the request is on the channel this cycle.
        S_RD_ISSUE: begin
          if (expired) begin
            err_timeout_q <= 1'b1;
            state_q       <= S_IDLE;
          end else if (hrv_q) begin
            state_q <= S_RD_WAIT;
          end else begin
            hrv_q <= !bus.host_rd_almfull;
          end
        end
        S_RD_WAIT: begin
          if (bus.host_rd_rsp_valid) begin
            rdata_q <= bus.host_rd_rsp_data;
            dv_q    <= 1'b1;
            state_q <= S_IDLE;
          end else if (expired) begin
            err_timeout_q <= 1'b1;
            state_q       <= S_IDLE;
          end
        end
        S_WR_ISSUE: begin
          if (expired) begin
            err_timeout_q <= 1'b1;
            state_q       <= S_IDLE;
          end else if (hwv_q) begin
            state_q <= S_WR_WAIT;
          end else begin
            hwv_q <= !bus.host_wr_almfull;
          end
        end
        S_WR_WAIT: begin
          if (bus.host_wr_rsp_valid) begin
            wd_q    <= 1'b1;
            state_q <= S_IDLE;
          end else if (expired) begin
            err_timeout_q <= 1'b1;
            state_q       <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.buffer_addr_valid = bav_q;
  assign bus.data_valid        = dv_q;
  assign bus.read_data         = rdata_q;
  assign bus.write_done        = wd_q;
  assign bus.host_rd_valid     = hrv_q;
  assign bus.host_rd_addr      = haddr_q;
  assign bus.host_wr_valid     = hwv_q;
  assign bus.host_wr_addr      = haddr_q;
  assign bus.host_wr_data      = wdata_q;
  assign bus.err_drop          = err_drop_q;
  assign bus.err_timeout       = err_timeout_q;
  assign bus.err_unexp         = err_unexp_q;

endmodule

`default_nettype wire

// File: tb/tb_ctrl_mem_responder.sv
// ============================================================================
// Module   : tb_ctrl_mem_responder
// Brief    : Directed self-checking bench for ctrl_mem_responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ctrl_mem_responder;
  import ctrl_mem_pkg::*;

  localparam int HADDR_W = 42;
  localparam int TMO     = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  ctrl_mem_responder_if #(.HADDR_W(HADDR_W)) bus ();

  ctrl_mem_responder #(
    .HADDR_W (HADDR_W),
    .TIMEOUT (TMO),
    .BUF_OFS (16'h0020)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [PAGE_W-1:0] got,
                     input logic [PAGE_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [15:0] a, input logic [63:0] d);
    bus.cfg_wr_valid = 1'b1;
    bus.cfg_wr_addr  = a;
    bus.cfg_wr_data  = d;
    step();
    bus.cfg_wr_valid = 1'b0;
  endtask

  logic [PAGE_W-1:0] pat_a5;
  logic [PAGE_W-1:0] pat_wr;
  logic              dv_seen;

  initial begin
    bus.address             = '0;
    bus.read_request_valid  = 1'b0;
    bus.write_request_valid = 1'b0;
    bus.write_data          = '0;
    bus.cfg_wr_valid        = 1'b0;
    bus.cfg_wr_addr         = '0;
    bus.cfg_wr_data         = '0;
    bus.host_rd_almfull     = 1'b0;
    bus.host_rd_rsp_valid   = 1'b0;
    bus.host_rd_rsp_data    = '0;
    bus.host_wr_almfull     = 1'b0;
    bus.host_wr_rsp_valid   = 1'b0;
    pat_a5 = {64{8'hA5}};
    pat_wr = {{480{1'b0}}, 32'hDEADBEEF};

    // ---- reset state
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_bav",       bus.buffer_addr_valid, 0);
    chk("rst_dv",        bus.data_valid, 0);
    chk("rst_rdata",     bus.read_data, 0);
    chk("rst_hrv",       bus.host_rd_valid, 0);
    chk("rst_errs",      {bus.err_drop, bus.err_timeout, bus.err_unexp}, 0);

    // ---- request before MMIO programming is dropped
    bus.address = 32'd1;
    bus.read_request_valid = 1'b1;
    step();
    bus.read_request_valid = 1'b0;
    chk("early_hrv",  bus.host_rd_valid, 0);
    chk("early_drop", bus.err_drop, 1);
    step();
    chk("early_hrv2", bus.host_rd_valid, 0);
    rst = 1'b1; step(); rst = 1'b0;

    // ---- MMIO: other offsets ignored, BUF_OFS programs the base
    cfg_write(16'h0028, 64'h1000);
    chk("mmio_other", bus.buffer_addr_valid, 0);
    cfg_write(16'h0020, 64'h1000);
    chk("mmio_bav", bus.buffer_addr_valid, 1);

    // ---- read: address 5 -> host line 0x1005
    bus.address = 32'd5;
    bus.read_request_valid = 1'b1;
    step();
    bus.read_request_valid = 1'b0;
    chk("rd_hrv",  bus.host_rd_valid, 1);
    chk("rd_addr", bus.host_rd_addr, 42'h1005);
    step();
    chk("rd_hrv_once", bus.host_rd_valid, 0);
    bus.host_rd_rsp_valid = 1'b1;
    bus.host_rd_rsp_data  = pat_a5;
    step();
    bus.host_rd_rsp_valid = 1'b0;
    bus.host_rd_rsp_data  = '0;
    chk("rd_dv",    bus.data_valid, 1);
    chk("rd_data",  bus.read_data, pat_a5);
    step();
    chk("rd_dv_pulse", bus.data_valid, 0);
    chk("rd_hold",     bus.read_data, pat_a5);
    chk("rd_noerr",    {bus.err_drop, bus.err_timeout, bus.err_unexp}, 0);

    // ---- write with almfull held three cycles
    bus.host_wr_almfull = 1'b1;
    bus.address = 32'd2;
    bus.write_data = pat_wr;
    bus.write_request_valid = 1'b1;
    step();                                   // T+1
    bus.write_request_valid = 1'b0;
    chk("wr_stall1", bus.host_wr_valid, 0);
    step();                                   // T+2
    chk("wr_stall2", bus.host_wr_valid, 0);
    step();                                   // T+3
    chk("wr_stall3", bus.host_wr_valid, 0);
    bus.host_wr_almfull = 1'b0;
    step();                                   // T+4
    chk("wr_hwv",  bus.host_wr_valid, 1);
    chk("wr_addr", bus.host_wr_addr, 42'h1002);
    chk("wr_data", bus.host_wr_data, pat_wr);
    step();
    chk("wr_hwv_once", bus.host_wr_valid, 0);
    bus.host_wr_rsp_valid = 1'b1;
    step();
    bus.host_wr_rsp_valid = 1'b0;
    chk("wr_done", bus.write_done, 1);
    step();
    chk("wr_done_pulse", bus.write_done, 0);
    chk("wr_noerr", {bus.err_drop, bus.err_timeout, bus.err_unexp}, 0);

    // ---- simultaneous read + write: write wins, read dropped
    bus.address = 32'd7;
    bus.read_request_valid  = 1'b1;
    bus.write_request_valid = 1'b1;
    step();
    bus.read_request_valid  = 1'b0;
    bus.write_request_valid = 1'b0;
    chk("sim_hwv",  bus.host_wr_valid, 1);
    chk("sim_hrv",  bus.host_rd_valid, 0);
    chk("sim_addr", bus.host_wr_addr, 42'h1007);
    chk("sim_drop", bus.err_drop, 1);
    step();
    bus.host_wr_rsp_valid = 1'b1;
    step();
    bus.host_wr_rsp_valid = 1'b0;
    chk("sim_done", bus.write_done, 1);

    // ---- wrap-around: base 2^42-1 + 3 -> 2
    cfg_write(16'h0020, 64'h0000_03FF_FFFF_FFFF);
    bus.address = 32'd3;
    bus.read_request_valid = 1'b1;
    step();
    bus.read_request_valid = 1'b0;
    chk("wrap_hrv",  bus.host_rd_valid, 1);
    chk("wrap_addr", bus.host_rd_addr, 42'h2);
    step();
    bus.host_rd_rsp_valid = 1'b1;
    bus.host_rd_rsp_data  = {{448{1'b0}}, 64'h1234};
    step();
    bus.host_rd_rsp_valid = 1'b0;
    chk("wrap_dv", bus.data_valid, 1);
    chk("wrap_data", bus.read_data, {{448{1'b0}}, 64'h1234});

    // ---- timeout: no host response
    bus.address = 32'd1;
    bus.read_request_valid = 1'b1;
    step();                                   // T+1, counter 0
    bus.read_request_valid = 1'b0;
    chk("tmo_hrv", bus.host_rd_valid, 1);
    dv_seen = 1'b0;
    for (int i = 0; i < TMO - 1; i++) begin   // reach T+16
      step();
      dv_seen = dv_seen | bus.data_valid;
    end
    chk("tmo_not_yet", bus.err_timeout, 0);
    step();                                   // T+17
    dv_seen = dv_seen | bus.data_valid;
    chk("tmo_flag", bus.err_timeout, 1);
    chk("tmo_no_dv", dv_seen, 0);
    chk("tmo_unexp_clear", bus.err_unexp, 0);
    bus.host_rd_rsp_valid = 1'b1;
    step();
    bus.host_rd_rsp_valid = 1'b0;
    chk("late_unexp", bus.err_unexp, 1);
    chk("late_no_dv", bus.data_valid, 0);
    // back in IDLE: a fresh request is taken immediately
    bus.address = 32'd4;
    bus.read_request_valid = 1'b1;
    step();
    bus.read_request_valid = 1'b0;
    chk("post_tmo_hrv",  bus.host_rd_valid, 1);
    chk("post_tmo_addr", bus.host_rd_addr, 42'h3);

    // ---- reset mid-read (now in RD_WAIT)
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_bav",   bus.buffer_addr_valid, 0);
    chk("mrst_hrv",   bus.host_rd_valid, 0);
    chk("mrst_addr",  bus.host_rd_addr, 0);
    chk("mrst_rdata", bus.read_data, 0);
    chk("mrst_errs",  {bus.err_drop, bus.err_timeout, bus.err_unexp}, 0);
    bus.host_rd_rsp_valid = 1'b1;
    step();
    bus.host_rd_rsp_valid = 1'b0;
    chk("mrst_unexp", bus.err_unexp, 1);
    chk("mrst_no_dv", bus.data_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ctrl_mem_responder.md
# ctrl_mem_responder

Memory-side responder for the control unit's page request interface. It accepts single-page (512-bit) read and write requests addressed in page units relative to a host buffer, translates them into host cache-line requests, and returns `data_valid` / `write_done` pulses with the data. It also owns the buffer base register, programmed over MMIO, that gates `buffer_addr_valid`. Sits between the control unit and the host memory channel.

## Interface
- `HADDR_W`, 42: host cache-line address width.
- `TIMEOUT`, 4096: cycles allowed in a wait state before abort.
- `BUF_OFS`, 16'h0020: MMIO offset of the buffer base register.
- `clk  in  1`: clock. One clock domain.
- `rst  in  1`: synchronous, active-high reset.
- `address  in  32`: page index from the control unit.
- `read_request_valid  in  1`: read request, sampled each cycle.
- `write_request_valid  in  1`: write request, sampled each cycle.
- `write_data  in  512`: write payload, sampled with `write_request_valid`.
- `buffer_addr_valid  out  1`: buffer base has been programmed.
- `data_valid  out  1`: one-cycle read-completion pulse.
- `read_data  out  512`: read payload. Valid with `data_valid` and held afterwards.
- `write_done  out  1`: one-cycle write-completion pulse.
- `cfg_wr_valid  in  1`, `cfg_wr_addr  in  16`, `cfg_wr_data  in  64`: MMIO write port.
- `host_rd_valid  out  1`, `host_rd_addr  out  HADDR_W`, `host_rd_almfull  in  1`: host read request channel.
- `host_rd_rsp_valid  in  1`, `host_rd_rsp_data  in  512`: host read response channel.
- `host_wr_valid  out  1`, `host_wr_addr  out  HADDR_W`, `host_wr_data  out  512`, `host_wr_almfull  in  1`: host write request channel.
- `host_wr_rsp_valid  in  1`: host write acknowledge.
- `err_drop  out  1`, `err_timeout  out  1`, `err_unexp  out  1`: sticky error flags.

## Operation
- **Buffer base register**
  - A `cfg_wr_valid` with `cfg_wr_addr == BUF_OFS` loads `buf_base <= cfg_wr_data[HADDR_W-1:0]` and sets `buffer_addr_valid`.
  - `buffer_addr_valid` clears only on `rst`. Rewriting the register updates `buf_base`; the flag stays 1.
  - Writes to other offsets are ignored.
- **Address translation**: host address = `buf_base + address` (zero-extended), truncated mod 2^HADDR_W. Wrap-around is legal and not flagged.
- **FSM states**: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT.
  - In IDLE with `buffer_addr_valid == 1`:
    - `write_request_valid` → WR_ISSUE. The translated address and `write_data` are latched.
    - Otherwise, `read_request_valid` → RD_ISSUE. The translated address is latched.
  - Simultaneous read and write requests: the write wins. The read is dropped and `err_drop` is set.
  - RD_ISSUE: assert `host_rd_valid` for exactly one cycle, on the first cycle `host_rd_almfull == 0`, then go to RD_WAIT. WR_ISSUE behaves the same with the write channel.
  - RD_WAIT: on `host_rd_rsp_valid`, register the data to `read_data`, pulse `data_valid`, go to IDLE.
  - WR_WAIT: on `host_wr_rsp_valid`, pulse `write_done`, go to IDLE.
- **Drops**: any request that arrives while not in IDLE, or while `buffer_addr_valid == 0`, is dropped and sets `err_drop`. Only one request is outstanding at a time. A level-held request is re-accepted once back in IDLE.
- **Timeout**: a 0-based wait counter starts on entry to RD_ISSUE/WR_ISSUE. On reaching `TIMEOUT-1` without completion: set `err_timeout`, return to IDLE, emit no completion pulse.
- **Unexpected responses**: a host response in a state not waiting for it is ignored and sets `err_unexp`. This includes late responses arriving after a timeout or after `rst`.
- **Error flags** clear only on `rst`.

## Timing
- **Reset values**: all outputs 0, `read_data` 0, `buf_base` 0, FSM in IDLE, counter 0.
- **Request to host**: request sampled in IDLE at cycle T → `host_rd_valid`/`host_wr_valid` at T+1 if `almfull == 0`, otherwise the first later cycle with `almfull == 0`.
- **Response to completion**: host response at cycle R → `data_valid`/`write_done` at R+1. The FSM is in IDLE at R+1, so a new request can be accepted at R+1.
- **Minimum round trip**: request → completion is 3 cycles when the host answers in the cycle after issue.
- **MMIO**: `cfg_wr_valid` at cycle C → `buffer_addr_valid == 1` at C+1. A request sampled at C is still dropped.
- **Reset mid-operation**: `rst` aborts any transaction. No completion pulse is emitted for it.
- All outputs are registered.

## Structure
- Package `ctrl_mem_pkg`:
  - typedef `mem_resp_state_t` (5 states);
  - `BUF_OFS` default;
  - localparam page width 512.
- Sub-module `mem_resp_timeout`: loadable/clearable wait counter with an expiry flag, parameterized by `TIMEOUT`.

## Test plan
- **MMIO and read**: program `BUF_OFS` with `0x1000`, then read request with `address == 5` → `host_rd_addr == 0x1005` at T+1. Host response `0xA5..A5` → `data_valid` pulse plus that data one cycle later.
- **Write**: write `address == 2`, data `0x..DEADBEEF`, `almfull` held 3 cycles → single `host_wr_valid` on cycle T+4 with address `0x1002`. Ack → `write_done` pulse.
- **Simultaneous and early requests**:
  - read+write in the same IDLE cycle → only the write is issued; `err_drop == 1`.
  - a request before any MMIO write → dropped; `err_drop == 1`.
- **Timeout**: `TIMEOUT == 16`, no host response → `err_timeout == 1` after 16 cycles, FSM back in IDLE, no `data_valid`. A late response then sets `err_unexp`.
- **Wrap-around**: `buf_base == 2^42-1`, `address == 3` → `host_rd_addr == 2`.
- **Reset mid-read**: `rst` in RD_WAIT → all outputs 0 next cycle and `buffer_addr_valid == 0`. A subsequent response sets `err_unexp` and produces no `data_valid`.
